// File: rtl/fp_accum32_if.sv
// rtl/fp_accum32_if.sv - operand stream, adder hookup and result stream of fp_accum32
interface fp_accum32_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_sub;
    logic             in_last;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_op_sub;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    // master: producer, external adder and consumer side
    modport master (
        output in_valid, in_data, in_sub, in_last, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_op_sub, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_sub, in_last, add_sum, out_ready,
        output in_ready, add_a, add_b, add_op_sub, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fp_accum32.sv
// rtl/fp_accum32.sv - running-sum controller wrapped around a combinational fp32 adder
module fp_accum32 #(
    parameter int LEN   = 16,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_accum32_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_acc;
    logic [31:0]      w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;

    // in_ready is gated by rst_n so it drops the instant reset asserts
    assign bus.in_ready   = rst_n & ((r_state == S_IDLE) | (r_state == S_ACCUM));
    assign bus.out_valid  = (r_state == S_HOLD);
    assign bus.out_data   = r_acc;
    assign bus.out_count  = r_cnt;
    assign bus.add_a      = r_acc;
    assign bus.add_b      = bus.in_data;
    assign bus.add_op_sub = bus.in_sub;

    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 32'h0000_0000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // First term is loaded directly; subtraction only needs a sign flip
                    w_acc_next = bus.in_sub ? {~bus.in_data[31], bus.in_data[30:0]} : bus.in_data;
                    w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_next     = (bus.in_last || LEN == 1) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_acc_next = bus.add_sum;
                    w_cnt_next = w_cnt_inc;
                    w_next     = (bus.in_last || w_cnt_inc == CNT_W'(LEN)) ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_acc_next = 32'h0000_0000;
                    w_cnt_next = '0;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_acc_next = 32'h0000_0000;
                w_cnt_next = '0;
                w_next     = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_fp_accum32.sv
// tb/tb_fp_accum32.sv - directed bench for fp_accum32 with a real-valued accumulation model
module tb_fp_accum32;
    localparam int LEN   = 16;
    localparam int CNT_W = 5;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    fp_accum32_if #(.CNT_W(CNT_W)) bus ();

    fp_accum32 #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) begin
            d = {f[31], 63'd0};
        end else begin
            e = {3'b000, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Stand-in for fpAdder32
    always_comb begin
        bus.add_sum = r2f(f2r(bus.add_a) + (bus.add_op_sub ? -f2r(bus.add_b) : f2r(bus.add_b)));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the group is the list of signed terms accepted so far
    bit  m_hold = 1'b0;
    real m_sum  = 0.0;
    int  m_cnt  = 0;

    always @(negedge clk) begin
        real term;
        if (!rst_n) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            m_hold = 1'b0;
            m_sum  = 0.0;
            m_cnt  = 0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
            chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
            chk("add_a", bus.add_a, r2f(m_sum));
            chk("add_b", bus.add_b, bus.in_data);
            chk("add_op_sub", 32'(bus.add_op_sub), 32'(bus.in_sub));
            if (m_hold) begin
                chk("out_data", bus.out_data, r2f(m_sum));
                chk("out_count", 32'(bus.out_count), 32'(m_cnt));
                if (bus.out_ready) begin
                    m_hold = 1'b0;
                    m_sum  = 0.0;
                    m_cnt  = 0;
                end
            end else if (bus.in_valid) begin
                term  = bus.in_sub ? -f2r(bus.in_data) : f2r(bus.in_data);
                m_sum = (m_cnt == 0) ? term : m_sum + term;
                m_cnt++;
                if (bus.in_last || m_cnt == LEN) m_hold = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int   g;
        logic took;
        g    = 0;
        took = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sub   = s;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!took && g < 200);
        if (!took) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
        end
        bus.in_valid = 1'b0;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset in the middle of a group
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("postrst_acc", bus.out_data, 32'h0);
        chk("postrst_cnt", 32'(bus.out_count), 32'd0);
        @(posedge clk);
        #1;

        // 1 + 2 + 3
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40400000, 1'b0, 1'b1);
        @(negedge clk);
        chk("sum_valid", 32'(bus.out_valid), 32'd1);
        chk("sum_data", bus.out_data, 32'h40C00000);
        chk("sum_count", 32'(bus.out_count), 32'd3);
        idle(2);

        // -4 + 2 with a backpressured result
        bus.out_ready = 1'b0;
        send(32'h40800000, 1'b1, 1'b0);
        @(negedge clk);
        chk("sub_load", bus.add_a, 32'hC0800000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("sub_add_a", bus.add_a, 32'hC0800000);
        chk("sub_add_b", bus.add_b, 32'h40000000);
        chk("sub_op", 32'(bus.add_op_sub), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", bus.out_data, 32'hC0000000);
            chk("bp_count", 32'(bus.out_count), 32'd2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Auto-close at LEN and a 17th operand waiting behind the result
        bus.out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) send(32'h3F800000, 1'b0, 1'b0);
        @(negedge clk);
        chk("auto_count", 32'(bus.out_count), 32'd16);
        chk("auto_data", bus.out_data, 32'h41800000);
        chk("auto_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("auto_blocked", 32'(bus.out_count), 32'd16);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'h40000000, 1'b0, 1'b1);
        @(negedge clk);
        chk("next_group_data", bus.out_data, 32'h40000000);
        chk("next_group_count", 32'(bus.out_count), 32'd1);
        idle(2);

        // Bubbles between four ones
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h3F800000, 1'b0, i == 3);
            if (i < 3) idle(1);
        end
        @(negedge clk);
        chk("bubble_data", bus.out_data, 32'h40800000);
        chk("bubble_count", 32'(bus.out_count), 32'd4);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
